// File: rtl/idi_arb_pkg.sv
// Shared types and constants for the IDI round-robin arbiter.
// Optional build macro used by the arbiter: IDI_ARB_TIMEOUT_EN.
package idi_arb_pkg;

  // Transaction FSM: one request is held from grant until its completion pulse.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  // Default abort threshold in cycles. It only matters when the timeout
  // feature is compiled in.
  localparam int DEF_TIMEOUT_CYC = 256;

  // Read data returned on an aborted read. It is kept wide and sliced by
  // the user down to its data width, which supports DATA_W up to 256.
  localparam int MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/idi_rr_arbiter_rr_pick.sv
// Combinational round-robin selector. The search starts one position past
// 'last' and wraps modulo NUM_REQ. The first set valid bit wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan NUM_REQ candidates in priority order and keep the first hit.
  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    c     = 0;
    ci    = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c  = (int'(last) + k) % NUM_REQ;
      ci = IDX_W'(c);
      if (!any && valid[ci]) begin
        any       = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/idi_rr_arbiter.sv
// Round-robin arbiter that shares one IDI bridge port between NUM_REQ
// requesters. It carries one transaction at a time.
// Optional build macro: IDI_ARB_TIMEOUT_EN. When it is defined, a transaction
// stuck in ISSUE or RD_WAIT is aborted after TIMEOUT_CYC cycles.
//
// Handshakes:
//   Requester side: req_valid[i] and its fields stay stable until
//   req_ready[i]. req_ready is a one-cycle accept pulse, and the fields are
//   captured on that edge. req_rvalid[i] (plus req_err[i] on abort) is a
//   one-cycle completion pulse. req_rdata is meaningful with req_rvalid for
//   reads only.
//   Bridge side: ds_valid stays high with stable ds_* until a cycle where
//   ds_valid && ds_ready. ds_ready is ignored outside ISSUE. ds_rvalid is a
//   single pulse that is sampled only in RD_WAIT and dropped otherwise.
module idi_rr_arbiter
  import idi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_is_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]          req_rvalid,
  output logic [NUM_REQ-1:0]          req_err,
  output logic                        ds_valid,
  input  logic                        ds_ready,
  output logic                        ds_is_write,
  output logic [ADDR_W-1:0]           ds_addr,
  output logic [DATA_W-1:0]           ds_wdata,
  input  logic [DATA_W-1:0]           ds_rdata,
  input  logic                        ds_rvalid,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    grant_q;
  logic                is_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [NUM_REQ-1:0]  grant_oh;

  logic                take;      // accept a new request this cycle
  logic                issue_hs;  // bridge accepted the request
  logic                rd_hit;    // bridge returned read data
  logic                abort;     // timeout fired without completion

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign take     = (state_q == IDLE) && pick_any;
  assign issue_hs = (state_q == ISSUE) && ds_ready;
  assign rd_hit   = (state_q == RD_WAIT) && ds_rvalid;
  assign grant_oh = NUM_REQ'(1) << grant_q;

`ifdef IDI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timeout_hit;

  assign timeout_hit = ((state_q == ISSUE) || (state_q == RD_WAIT)) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  // A completion in the same cycle as the threshold wins over the abort.
  assign abort       = timeout_hit && !issue_hs && !rd_hit;

  // Count the cycles spent waiting on the bridge. The count restarts with
  // each new transaction and freezes once the threshold is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= '0;
    end else if (((state_q == ISSUE) || (state_q == RD_WAIT)) && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Remember that the current transaction was aborted, so DONE reports it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end else if (state_q == DONE) begin
      err_q <= 1'b0;
    end
  end

  assign req_err = ((state_q == DONE) && err_q) ? grant_oh : '0;
`else
  assign abort   = 1'b0;
  assign req_err = '0;
`endif

  // State register, round-robin pointer and capture of the winning request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q <= pick_idx;
        last_q  <= pick_idx;
        is_wr_q <= req_is_write[pick_idx];
        addr_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[pick_idx*DATA_W +: DATA_W];
      end
      if (rd_hit) begin
        rdata_q <= ds_rdata;
      end else if (abort && !is_wr_q) begin
        rdata_q <= ERR_RDATA[DATA_W-1:0];
      end
    end
  end

  // Next-state logic for the single in-flight transaction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = ISSUE;
      end
      ISSUE: begin
        if (issue_hs)   state_d = is_wr_q ? DONE : RD_WAIT;
        else if (abort) state_d = DONE;
      end
      RD_WAIT: begin
        if (rd_hit || abort) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Requester-facing and bridge-facing outputs decoded from state. The
  // accept pulse is also gated by reset, so every output reads 0 while
  // rst_n is low.
  always_comb begin
    req_ready   = (rst_n && (state_q == IDLE)) ? pick_grant : '0;
    req_rvalid  = (state_q == DONE) ? grant_oh : '0;
    req_rdata   = rdata_q;
    ds_valid    = (state_q == ISSUE);
    ds_is_write = is_wr_q;
    ds_addr     = addr_q;
    ds_wdata    = wdata_q;
    grant_id    = grant_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: doc/idi_rr_arbiter.md
Name: idi_rr_arbiter

Overview:
Round-robin arbiter that shares the single IDI port of the idi_to_axi bridge between NUM_REQ IDI requesters. It holds one transaction at a time and captures the winner's request into registers. It drives the bridge, then returns read data, or a completion for writes, to the granted requester only. It sits between requester agents and idi_to_axi in top.

Parameters:
NUM_REQ, 4, number of IDI requesters (2..8)
ADDR_W, 64, IDI address width
DATA_W, 32, IDI data width
TIMEOUT_CYC, 256, cycles before abort (used only with IDI_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept pulse
req_is_write  input  NUM_REQ  1=write, 0=read
req_addr  input  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  flattened write data
req_rdata  output  DATA_W  read data, shared by all requesters, qualified by req_rvalid
req_rvalid  output  NUM_REQ  per-requester read-data / write-done pulse
req_err  output  NUM_REQ  per-requester abort pulse; constant 0 without the macro
ds_valid  output  1  to bridge idi_valid
ds_ready  input  1  from bridge idi_ready
ds_is_write  output  1  to bridge
ds_addr  output  ADDR_W  to bridge
ds_wdata  output  DATA_W  to bridge
ds_rdata  input  DATA_W  from bridge idi_rdata
ds_rvalid  input  1  from bridge idi_rvalid
grant_id  output  $clog2(NUM_REQ)  current or last granted requester
busy  output  1  1 when state != IDLE

Behaviour:
- Reset values (async, rst_n=0):
  - State = IDLE.
  - All outputs are 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
- A requester holds req_valid and its fields stable until it sees its req_ready.
- IDLE:
  - If any req_valid is set, pick the first set bit searching last+1, last+2, … mod NUM_REQ.
  - In that same cycle T: req_ready[g]=1 (combinational), and at the edge capture is_write, addr and wdata into registers. Also set grant_id=g, last=g, state=ISSUE.
  - No other req_ready bit is ever high.
- ISSUE:
  - ds_valid=1 and ds_* are driven from the captured registers, starting at cycle T+1.
  - On ds_valid && ds_ready: a write goes to DONE; a read goes to RD_WAIT.
- RD_WAIT: on ds_rvalid, register ds_rdata into req_rdata and go to DONE.
- DONE (one cycle):
  - req_rvalid[g]=1 for both reads and writes; req_rdata is valid for reads and holds its previous value for writes.
  - Next state is IDLE. Arbitration resumes the cycle after DONE, so the best case is 1 transaction per 3 cycles plus the bridge latency.
- ds_ready outside ISSUE is ignored. ds_rvalid outside RD_WAIT is ignored and dropped.
- Withdrawing req_valid before the grant is legal and is not counted. The request is captured, so later changes to req_* do not affect an in-flight transaction.
- busy=1 in ISSUE, RD_WAIT and DONE.
- Reset asserted mid-transaction returns to IDLE immediately and drops the in-flight transaction. Outputs go to their reset values.
- The pointer wraps from NUM_REQ-1 to 0. With all requesters valid, grants go 0,1,2,3,0,…

Optional Feature:
IDI_ARB_TIMEOUT_EN
- With the macro defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE or RD_WAIT.
  - When it reaches TIMEOUT_CYC-1 without completion, go to DONE with req_err[g]=1 alongside req_rvalid[g]=1. For reads, req_rdata is all ones.
  - The counter stops after the abort, and ds_valid drops.
- Without the macro: no counter, req_err is tied to 0, and the block waits indefinitely.

Decomposition:
- Package idi_arb_pkg:
  - State enum arb_state_e {IDLE, ISSUE, RD_WAIT, DONE}.
  - ERR_RDATA constant (all ones) and the default TIMEOUT_CYC.
- Sub-module rr_pick: combinational round-robin selector. Inputs are the valid vector and last; outputs are the one-hot grant and its index.
- The pointer register, FSM and capture registers stay in idi_rr_arbiter.

Test Plan:
- Write, single requester: req 2 writes addr 64'h100, data 32'hDEADBEEF, with ds_ready 2 cycles after ds_valid -> req_ready[2] at T; ds_valid from T+1 with ds_addr=64'h100, ds_wdata=32'hDEADBEEF; req_rvalid[2] one cycle after ds_ready.
- Read: req 1 reads 64'h100, bridge returns ds_rdata=32'hCAFEF00D -> req_rdata=32'hCAFEF00D with req_rvalid[1] the cycle after ds_rvalid.
- Fairness: all four requesters hold valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3, never two req_ready bits at once.
- Stray response: ds_rvalid pulsed while IDLE -> no req_rvalid and no state change. Then ds_ready held high in ISSUE for a write -> exactly one completion.
- Reset mid-read: rst_n low during RD_WAIT -> all outputs 0 within the same cycle; after release, the next grant goes to requester 0.
- Timeout (macro on, TIMEOUT_CYC=16): read with no ds_rvalid -> after 16 cycles req_err[g]=1, req_rvalid[g]=1, req_rdata=32'hFFFFFFFF, then IDLE.
